// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle MIPS-subset control FSM with memory wait timeout
module multi_cycle_controller #(
    parameter int ALUCTRL_W   = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           pc_src,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_b,
    output logic                 imm_sign_ext,
    output logic                 imm_high,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [2:0]           state,
    output logic                 bus_err,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instret
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_NOP = '1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_instret;

    logic [5:0] w_op;
    logic [5:0] w_func;
    logic       w_add, w_sub, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal;
    logic       w_rtype, w_legal;
    logic       w_waiting, w_timeout, w_retire;
    logic       w_unused_bits;

    assign w_op   = instr[31:26];
    assign w_func = instr[5:0];
    assign w_unused_bits = &{1'b0, instr[25:6]};

    assign w_add   = (w_op == 6'h00) && (w_func == 6'h20);
    assign w_sub   = (w_op == 6'h00) && (w_func == 6'h22);
    assign w_jr    = (w_op == 6'h00) && (w_func == 6'h08);
    assign w_ori   = (w_op == 6'h0D);
    assign w_lw    = (w_op == 6'h23);
    assign w_sw    = (w_op == 6'h2B);
    assign w_beq   = (w_op == 6'h04);
    assign w_lui   = (w_op == 6'h0F);
    assign w_jal   = (w_op == 6'h03);
    assign w_rtype = w_add | w_sub;
    assign w_legal = w_add | w_sub | w_jr | w_ori | w_lw | w_sw | w_beq | w_lui | w_jal;

    // mem_ready only matters while a request is outstanding
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == TIMEOUT_V);

    logic                 w_imem, w_dmem, w_mw, w_irw, w_pcw, w_rw;
    logic [1:0]           w_pcs, w_rd, w_wb;
    logic                 w_asb, w_se, w_ih, w_be, w_il;
    logic [ALUCTRL_W-1:0] w_alu;

    always_comb begin
        w_imem   = 1'b0;
        w_dmem   = 1'b0;
        w_mw     = 1'b0;
        w_irw    = 1'b0;
        w_pcw    = 1'b0;
        w_rw     = 1'b0;
        w_pcs    = 2'd0;
        w_rd     = 2'd0;
        w_wb     = 2'd0;
        w_asb    = 1'b0;
        w_se     = 1'b0;
        w_ih     = 1'b0;
        w_be     = 1'b0;
        w_il     = 1'b0;
        w_alu    = ALU_NOP;
        w_retire = 1'b0;
        w_next   = r_state;
        case (r_state)
            S_FETCH: begin
                w_imem = 1'b1;
                if (mem_ready) begin
                    w_irw  = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_be   = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_jal) begin
                    w_rw     = 1'b1;
                    w_rd     = 2'd2;
                    w_wb     = 2'd2;
                    w_pcw    = 1'b1;
                    w_pcs    = 2'd2;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_jr) begin
                    w_pcw    = 1'b1;
                    w_pcs    = 2'd3;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (!w_legal) begin
                    w_il   = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_add || w_lw || w_sw) begin
                    w_alu = ALU_ADD;
                end else if (w_sub || w_beq) begin
                    w_alu = ALU_SUB;
                end else if (w_ori || w_lui) begin
                    w_alu = ALU_OR;
                end
                w_asb = w_ori | w_lui | w_lw | w_sw;
                w_se  = w_lw | w_sw;
                w_ih  = w_lui;
                if (w_beq) begin
                    w_pcw    = zero;
                    w_pcs    = 2'd1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dmem = 1'b1;
                w_mw   = w_sw;
                if (mem_ready) begin
                    if (w_sw) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    // an aborted store must not leave a write strobe behind
                    w_mw   = 1'b0;
                    w_be   = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_WB: begin
                w_rw     = 1'b1;
                w_rd     = w_rtype ? 2'd1 : 2'd0;
                w_wb     = w_lw ? 2'd1 : 2'd0;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_instret  <= '0;
        end else begin
            r_state <= w_next;
            // a timeout re-enters FETCH, which still counts as a fresh start
            if ((w_next != r_state) || w_timeout) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign imem_req     = w_imem & reset;
    assign dmem_req     = w_dmem & reset;
    assign mem_write    = w_mw & reset;
    assign ir_write     = w_irw & reset;
    assign pc_write     = w_pcw & reset;
    assign reg_write    = w_rw & reset;
    assign pc_src       = reset ? w_pcs : 2'd0;
    assign reg_dst      = reset ? w_rd : 2'd0;
    assign wb_sel       = reset ? w_wb : 2'd0;
    assign alu_src_b    = w_asb & reset;
    assign imm_sign_ext = w_se & reset;
    assign imm_high     = w_ih & reset;
    assign alu_ctrl     = reset ? w_alu : ALU_NOP;
    assign bus_err      = w_be & reset;
    assign illegal      = w_il & reset;
    assign state        = r_state;
    assign instret      = r_instret;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - scoreboard bench for multi_cycle_controller
module tb_multi_cycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write;
    logic [1:0]  pc_src, reg_dst, wb_sel;
    logic        alu_src_b, imm_sign_ext, imm_high;
    logic [2:0]  alu_ctrl;
    logic [2:0]  state;
    logic        bus_err, illegal;
    logic [3:0]  instret;

    multi_cycle_controller #(
        .ALUCTRL_W  (3),
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .pc_src      (pc_src),
        .reg_dst     (reg_dst),
        .wb_sel      (wb_sel),
        .alu_src_b   (alu_src_b),
        .imm_sign_ext(imm_sign_ext),
        .imm_high    (imm_high),
        .alu_ctrl    (alu_ctrl),
        .state       (state),
        .bus_err     (bus_err),
        .illegal     (illegal),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [19:0] ctl;
        logic [3:0] ret;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_ret  = 4'd0;

    logic [19:0] w_obs;
    assign w_obs = {imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write,
                    pc_src, reg_dst, wb_sel, alu_src_b, imm_sign_ext, imm_high,
                    alu_ctrl, bus_err, illegal};

    function automatic logic [19:0] mk(input bit imem, input bit dmem, input bit mw,
                                       input bit irw, input bit pcw, input bit rw,
                                       input logic [1:0] pcs, input logic [1:0] rd,
                                       input logic [1:0] wb, input bit asb, input bit se,
                                       input bit ih, input logic [2:0] alu,
                                       input bit be, input bit il);
        return {imem, dmem, mw, irw, pcw, rw, pcs, rd, wb, asb, se, ih, alu, be, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive, record expectation, compare settled outputs, advance
    task automatic cyc(input string tag, input logic [31:0] ins, input bit mr, input bit z,
                       input logic [2:0] st, input logic [19:0] ctl, input bit ret);
        exp_t e;
        instr     = ins;
        mem_ready = mr;
        zero      = z;
        e.tag = tag;
        e.st  = st;
        e.ctl = ctl;
        e.ret = exp_ret;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            check({tag, ":sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ":state"}, 32'(state), 32'(e.st));
            check({e.tag, ":ctl"}, 32'(w_obs), 32'(e.ctl));
            check({e.tag, ":instret"}, 32'(instret), 32'(e.ret));
        end
        if (ret) exp_ret = exp_ret + 4'd1;
        @(negedge clk);
    endtask

    logic [19:0] c_idle, c_fetch, c_fwait, c_fto;

    task automatic fetch(input string tag, input logic [31:0] ins);
        cyc({tag, ":F"}, ins, 1'b1, 1'b0, 3'd0, c_fetch, 1'b0);
    endtask

    task automatic decode(input string tag, input logic [31:0] ins);
        cyc({tag, ":D"}, ins, 1'b1, 1'b0, 3'd1, c_idle, 1'b0);
    endtask

    task automatic run_jal(input string tag);
        fetch(tag, 32'h0C000010);
        cyc({tag, ":D"}, 32'h0C000010, 1'b1, 1'b0, 3'd1,
            mk(0,0,0,0,1,1, 2'd2,2'd2,2'd2, 0,0,0, 3'd7, 0,0), 1'b1);
    endtask

    initial begin
        c_idle  = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0);
        c_fetch = mk(1,0,0,1,1,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0);
        c_fwait = mk(1,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0);
        c_fto   = mk(1,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 1,0);

        reset = 1'b0;
        cyc("reset", 32'h34081234, 1'b1, 1'b0, 3'd0, c_idle, 1'b0);
        reset = 1'b1;

        // ori
        fetch("ori", 32'h34081234);
        decode("ori", 32'h34081234);
        cyc("ori:E", 32'h34081234, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,0,0, 3'd2, 0,0), 1'b0);
        cyc("ori:W", 32'h34081234, 1'b1, 1'b0, 3'd4, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        // lw with three memory wait cycles
        fetch("lw", 32'h8C080004);
        decode("lw", 32'h8C080004);
        cyc("lw:E", 32'h8C080004, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,1,0, 3'd0, 0,0), 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("lw:Mw", 32'h8C080004, 1'b0, 1'b0, 3'd3, mk(0,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b0);
        cyc("lw:M", 32'h8C080004, 1'b1, 1'b0, 3'd3, mk(0,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b0);
        cyc("lw:W", 32'h8C080004, 1'b1, 1'b0, 3'd4, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 0,0,0, 3'd7, 0,0), 1'b1);

        // beq taken and not taken
        fetch("beq1", 32'h10000003);
        decode("beq1", 32'h10000003);
        cyc("beq1:E", 32'h10000003, 1'b1, 1'b1, 3'd2, mk(0,0,0,0,1,0, 2'd1,2'd0,2'd0, 0,0,0, 3'd1, 0,0), 1'b1);
        fetch("beq0", 32'h10000003);
        decode("beq0", 32'h10000003);
        cyc("beq0:E", 32'h10000003, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd1,2'd0,2'd0, 0,0,0, 3'd1, 0,0), 1'b1);

        run_jal("jal");

        fetch("jr", 32'h03E00008);
        cyc("jr:D", 32'h03E00008, 1'b1, 1'b0, 3'd1, mk(0,0,0,0,1,0, 2'd3,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        fetch("ill", 32'hFC000000);
        cyc("ill:D", 32'hFC000000, 1'b1, 1'b0, 3'd1, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,1), 1'b0);

        fetch("add", 32'h01095020);
        decode("add", 32'h01095020);
        cyc("add:E", 32'h01095020, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd0, 0,0), 1'b0);
        cyc("add:W", 32'h01095020, 1'b1, 1'b0, 3'd4, mk(0,0,0,0,0,1, 2'd0,2'd1,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        fetch("sw", 32'hAC080004);
        decode("sw", 32'hAC080004);
        cyc("sw:E", 32'hAC080004, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,1,0, 3'd0, 0,0), 1'b0);
        cyc("sw:M", 32'hAC080004, 1'b1, 1'b0, 3'd3, mk(0,1,1,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        fetch("sub", 32'h01095022);
        decode("sub", 32'h01095022);
        cyc("sub:E", 32'h01095022, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd1, 0,0), 1'b0);
        cyc("sub:W", 32'h01095022, 1'b1, 1'b0, 3'd4, mk(0,0,0,0,0,1, 2'd0,2'd1,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        fetch("lui", 32'h3C081234);
        decode("lui", 32'h3C081234);
        cyc("lui:E", 32'h3C081234, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,0,1, 3'd2, 0,0), 1'b0);
        cyc("lui:W", 32'h3C081234, 1'b1, 1'b0, 3'd4, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        // fetch timeout twice in a row: counter must restart after the first abort
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++)
                cyc("to:wait", 32'h0, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0);
            cyc("to:err", 32'h0, 1'b0, 1'b0, 3'd0, c_fto, 1'b0);
        end

        // instret wraps at 4 bits
        for (int i = 0; i < 6; i++) run_jal("wrap");
        fetch("post_wrap", 32'h34081234);
        decode("post_wrap", 32'h34081234);
        cyc("post_wrap:E", 32'h34081234, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,0,0, 3'd2, 0,0), 1'b0);
        cyc("post_wrap:W", 32'h34081234, 1'b1, 1'b0, 3'd4, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);

        // reset asserted in the middle of a memory wait
        fetch("rst_lw", 32'h8C080004);
        decode("rst_lw", 32'h8C080004);
        cyc("rst_lw:E", 32'h8C080004, 1'b1, 1'b0, 3'd2, mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 1,1,0, 3'd0, 0,0), 1'b0);
        cyc("rst_lw:Mw", 32'h8C080004, 1'b0, 1'b0, 3'd3, mk(0,1,0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b0);
        reset   = 1'b0;
        exp_ret = 4'd0;
        cyc("rst_mid", 32'h8C080004, 1'b1, 1'b0, 3'd0, c_idle, 1'b0);
        cyc("rst_hold", 32'h8C080004, 1'b1, 1'b0, 3'd0, c_idle, 1'b0);
        reset = 1'b1;
        fetch("after_rst", 32'h03E00008);
        cyc("after_rst:D", 32'h03E00008, 1'b1, 1'b0, 3'd1, mk(0,0,0,0,1,0, 2'd3,2'd0,2'd0, 0,0,0, 3'd7, 0,0), 1'b1);
        cyc("after_rst:F", 32'h0, 1'b0, 1'b0, 3'd0, c_fwait, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3, SHALL set the width of alu_ctrl; codes ADD=0, SUB=1, OR=2, NOP=all-ones, zero-extended to ALUCTRL_W.
REQ-002 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum number of mem_ready wait cycles before abort; 0 disables the timeout.
REQ-003 Parameter CNT_W, default 32, SHALL set the width of instret.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 instr  in  32  instruction register contents, valid from DECODE onward.
REQ-007 mem_ready  in  1  memory completion for the current imem_req/dmem_req.
REQ-008 zero  in  1  ALU equality flag, sampled in EXEC.
REQ-009 imem_req / dmem_req  out  1 each  instruction-fetch / data-access request.
REQ-010 mem_write  out  1  data store strobe, valid with dmem_req.
REQ-011 ir_write / pc_write / reg_write  out  1 each  IR load / PC load / register-file write strobes.
REQ-012 pc_src  out  2  0=PC+4, 1=branch target, 2=jump index, 3=rs (jr).
REQ-013 reg_dst  out  2  0=rt, 1=rd, 2=$31.
REQ-014 wb_sel  out  2  0=ALU, 1=memory data, 2=PC register.
REQ-015 alu_src_b / imm_sign_ext / imm_high  out  1 each  immediate operand / sign-extend / immediate shifted to the upper half (lui).
REQ-016 alu_ctrl  out  ALUCTRL_W  ALU operation.
REQ-017 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-018 bus_err / illegal  out  1 each  single-cycle error pulses.
REQ-019 instret  out  CNT_W  retired-instruction count.

Function
REQ-020 The block SHALL decode op=instr[31:26] and func=instr[5:0] for add, sub, jr (op 0, func 0x20/0x22/0x08), ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F and jal 0x03; every other encoding is illegal.
REQ-021 All outputs SHALL be combinational from state, instr, zero, mem_ready and the wait counter; every strobe not listed for a state SHALL be 0, and alu_ctrl SHALL be NOP outside EXEC.
REQ-022 FETCH: imem_req=1; on mem_ready, ir_write=1 and pc_write=1 with pc_src=0, then go to DECODE; otherwise stay in FETCH.
REQ-023 DECODE, jal: reg_write=1, reg_dst=2, wb_sel=2, pc_write=1, pc_src=2, then go to FETCH and retire.
REQ-024 DECODE, jr: pc_write=1, pc_src=3, then go to FETCH and retire.
REQ-025 DECODE, illegal: illegal=1, then go to FETCH without retiring.
REQ-026 DECODE, any other instruction: go to EXEC.
REQ-027 EXEC, ALU codes: add/lw/sw=ADD, sub/beq=SUB, ori/lui=OR; alu_src_b=1 for ori/lui/lw/sw; imm_sign_ext=1 for lw/sw only; imm_high=1 for lui.
REQ-028 EXEC, beq: pc_write=zero, pc_src=1, then go to FETCH and retire.
REQ-029 EXEC, next state for other instructions: R-type/ori/lui go to WB; lw/sw go to MEM.
REQ-030 MEM: dmem_req=1 and mem_write=(op==sw); on mem_ready, sw goes to FETCH and retires, and lw goes to WB.
REQ-031 WB: reg_write=1; reg_dst=1 for R-type, 0 otherwise; wb_sel=1 for lw, 0 otherwise; then go to FETCH and retire.
REQ-032 Wait counter: clears on every state transition and increments each FETCH/MEM cycle with mem_ready=0.
REQ-033 Timeout: if MEM_TIMEOUT≠0, counter==MEM_TIMEOUT and mem_ready=0, then bus_err=1 for that cycle and the next state is FETCH; no strobes fire and the instruction does not retire.
REQ-034 mem_ready has priority over timeout in the same cycle; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-035 instret SHALL increment by 1 on each retire and wrap from 2^CNT_W-1 to 0.

Reset
REQ-036 While reset=0, state=FETCH, the wait counter=0 and instret=0 asynchronously, and every strobe, bus_err and illegal SHALL be forced to 0.
REQ-037 On the first clk edge after reset rises, FETCH SHALL behave normally.
REQ-038 A reset asserted in any state, including mid-MEM, SHALL abandon the instruction with no further strobes.

Verification
REQ-039 ori 0x34081234, mem_ready=1 -> states FETCH, DECODE, EXEC, WB over 4 cycles; EXEC alu_ctrl=2, alu_src_b=1, imm_sign_ext=0; WB reg_write=1, reg_dst=0; instret 0->1.
REQ-040 lw 0x8C080004, mem_ready low for 3 MEM cycles -> dmem_req held 4 cycles, mem_write=0; then WB with wb_sel=1; instret +1.
REQ-041 beq 0x10000003 -> zero=1: pc_write=1, pc_src=1 in EXEC; zero=0: pc_write=0; both retire.
REQ-042 MEM_TIMEOUT=4, mem_ready=0 after reset -> bus_err=1 on the 5th FETCH cycle only, FETCH re-entered with counter 0, instret unchanged.
REQ-043 jal 0x0C000010 -> DECODE reg_write=1, reg_dst=2, wb_sel=2, pc_src=2; instr 0xFC000000 -> illegal=1 for one cycle, instret unchanged.
REQ-044 instret at all-ones with CNT_W=4 plus one retire -> 0; reset low during MEM -> dmem_req=0 immediately, state=0, instret=0.
